// File: rtl/spi_frame_deserializer.sv
// spi_frame_deserializer: synchronizes mode-0 SPI pins into clk and decodes 16-bit {rw, addr, data} frames.
// Optional feature macro: SPI_FRAME_ERR_EN enables the frame_err_o strobe for short/long frames.
`default_nettype none

module spi_frame_deserializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       copi_i,
    input  logic       ncs_i,
    output logic       valid_o,
    output logic       read_write_o,
    output logic [6:0] addr_o,
    output logic [7:0] data_o,
    output logic       frame_err_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q, pin_vld_q;
    logic                   sclk_hist_q, ncs_hist_q, armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            pin_vld_q   <= '0;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_i};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_i};
            pin_vld_q   <= {pin_vld_q[SYNC_STAGES-2:0], 1'b1};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            ncs_hist_q  <= ncs_sync_q[SYNC_STAGES-1];
            // A falling ncs only counts once the pin has been seen high after reset.
            armed_q     <= armed_q | (pin_vld_q[SYNC_STAGES-1] & ncs_sync_q[SYNC_STAGES-1]);
        end
    end

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_fall, ncs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign ncs_fall  = ~ncs_s & ncs_hist_q & armed_q;
    assign ncs_rise  = ncs_s & ~ncs_hist_q;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        ferr_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d = ST_RECV;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_RECV: begin
                // ncs_rise takes priority so a coincident sclk edge never alters the count.
                if (ncs_rise) begin
                    state_d = ST_IDLE;
                    if (cnt_q == 5'd16) begin
                        rw_d    = shift_q[15];
                        addr_d  = shift_q[14:8];
                        data_d  = shift_q[7:0];
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_s};
                    if (cnt_q != 5'd17) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic ferr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
        end
    end

    assign frame_err_o = ferr_q;
`else
    logic unused_ferr;

    assign unused_ferr = ferr_d;
    assign frame_err_o = 1'b0;
`endif

    assign valid_o      = valid_q;
    assign read_write_o = rw_q;
    assign addr_o       = addr_q;
    assign data_o       = data_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_deserializer.sv
// tb_spi_frame_deserializer: scoreboard bench for spi_frame_deserializer driving SPI at clk/8.
`default_nettype none

module tb_spi_frame_deserializer;

    localparam int SYNC_STAGES = 2;
`ifdef SPI_FRAME_ERR_EN
    localparam int FERR_PER_BAD = 1;
`else
    localparam int FERR_PER_BAD = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       valid;
    logic       read_write;
    logic [6:0] addr;
    logic [7:0] data;
    logic       frame_err;

    spi_frame_deserializer #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk          (clk),
        .rst          (rst),
        .sclk_i       (sclk),
        .copi_i       (copi),
        .ncs_i        (ncs),
        .valid_o      (valid),
        .read_write_o (read_write),
        .addr_o       (addr),
        .data_o       (data),
        .frame_err_o  (frame_err)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          e0_cyc = 0;
    int          n_valid = 0;
    int          n_ferr = 0;
    logic [15:0] exp_q[$];
    logic [15:0] prev_out = '0;
    logic        rst_seen = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        logic [15:0] cur;
        logic [15:0] e;
        #1;
        cur = {read_write, addr, data};
        if (valid) begin
            n_valid++;
            check_eq("valid_latency", cyc - e0_cyc, SYNC_STAGES);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", cur, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("frame_fields", cur, e);
            end
        end else if (!rst && !rst_seen) begin
            check_eq("hold_without_valid", cur, prev_out);
        end
        if (frame_err) begin
            n_ferr++;
            check_eq("ferr_latency", cyc - e0_cyc, SYNC_STAGES);
        end
        prev_out = cur;
        rst_seen = rst;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        copi = b;
        tick(4);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic close_frame(input int gap);
        tick(4);
        ncs    = 1'b1;
        e0_cyc = cyc + 1;
        tick(gap);
    endtask

    // Sends the top nbits of a 17-bit-wide word, MSB first.
    task automatic send_frame(input logic [16:0] bits, input int nbits, input int gap);
        ncs = 1'b0;
        tick(4);
        for (int i = 16; i > 16 - nbits; i--) begin
            send_bit(bits[i]);
        end
        close_frame(gap);
    endtask

    task automatic good_frame(input logic [15:0] f, input int gap);
        exp_q.push_back(f);
        send_frame({f, 1'b0}, 16, gap);
    endtask

    initial begin
        int ferr_base;
        logic [15:0] w;

        tick(4);
        check_eq("reset_valid", valid, 0);
        check_eq("reset_fields", {read_write, addr, data}, 0);
        check_eq("reset_ferr", frame_err, 0);
        rst = 1'b0;
        tick(8);

        good_frame(16'h847F, 10);
        check_eq("rw_847F", read_write, 1);
        check_eq("addr_847F", addr, 7'h04);
        check_eq("data_847F", data, 8'h7F);

        ferr_base = n_ferr;
        send_frame({16'h0155, 1'b0}, 15, 10);
        send_frame({16'h0155, 1'b1}, 17, 10);
        check_eq("short_long_ferr", n_ferr - ferr_base, 2 * FERR_PER_BAD);
        check_eq("keep_847F", {read_write, addr, data}, 16'h847F);

        good_frame(16'h0155, 10);
        check_eq("rw_0155", read_write, 0);
        check_eq("addr_0155", addr, 7'h01);
        check_eq("data_0155", data, 8'h55);

        // Reset mid-frame with ncs held low: frame must vanish without any strobe.
        ferr_base = n_ferr;
        w = 16'h83AA;
        ncs = 1'b0;
        tick(4);
        for (int i = 15; i >= 8; i--) send_bit(w[i]);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        close_frame(10);
        check_eq("reset_drop_fields", {read_write, addr, data}, 0);
        check_eq("reset_drop_ferr", n_ferr - ferr_base, 0);
        check_eq("reset_drop_valid", n_valid, 2);

        good_frame(16'h8011, 2);
        good_frame(16'h8122, 10);
        check_eq("b2b_data", data, 8'h22);
        check_eq("b2b_valid", n_valid, 4);

        // 17th sclk rise coincides with ncs rise: the extra edge is ignored.
        w = 16'h8299;
        exp_q.push_back(w);
        ncs = 1'b0;
        tick(4);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
        copi = 1'b1;
        tick(4);
        sclk   = 1'b1;
        ncs    = 1'b1;
        e0_cyc = cyc + 1;
        tick(4);
        sclk = 1'b0;
        tick(10);
        check_eq("coinc_addr", addr, 7'h02);
        check_eq("coinc_data", data, 8'h99);

        check_eq("total_valid", n_valid, 5);
        check_eq("total_ferr", n_ferr, 2 * FERR_PER_BAD);
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
